// File: rtl/alu_cmd_queue.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : alu_cmd_queue
// Purpose  : Sequential front/back stage wrapped around the combinational ALU.
//            Commands {op, x, y, tag} are buffered in a FIFO. The head entry
//            drives the ALU operand ports. The ALU result and flags are
//            captured into an output slot that uses a valid/ready handshake.
// Revision : 1.0 - initial release
//
// Parameters
//   DEPTH  FIFO entries (power of 2, >= 2)
//   TAG_W  width of the opaque tag carried with each command
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   flush             synchronous clear of FIFO, result slot and sticky state
//   cmd_valid/ready   command handshake (cmd_ready == !full)
//   cmd_op/x/y/tag    command payload
//   alu_x/y/op        head entry to ALU (0/0/3'b111 when empty)
//   alu_z, alu_zero, alu_equal, alu_overflow   ALU result and flags
//   res_valid/ready   result handshake
//   res_z, res_flags  registered result, flags = {overflow, equal, zero}
//   res_tag           tag of the result
//   res_illegal       result came from the reserved op 3'b111
//   count             FIFO occupancy, 0..DEPTH
//   sticky_ovf        (ALU_STICKY_OVF_EN only) overflow seen since reset/flush
//
// Build option: define ALU_STICKY_OVF_EN to add the sticky_ovf output.
// ============================================================================
module alu_cmd_queue #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [2:0]              cmd_op,
    input  logic [31:0]             cmd_x,
    input  logic [31:0]             cmd_y,
    input  logic [TAG_W-1:0]        cmd_tag,
    output logic [31:0]             alu_x,
    output logic [31:0]             alu_y,
    output logic [2:0]              alu_op,
    input  logic [31:0]             alu_z,
    input  logic                    alu_zero,
    input  logic                    alu_equal,
    input  logic                    alu_overflow,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [31:0]             res_z,
    output logic [2:0]              res_flags,
    output logic [TAG_W-1:0]        res_tag,
    output logic                    res_illegal,
`ifdef ALU_STICKY_OVF_EN
    output logic                    sticky_ovf,
`endif
    output logic [$clog2(DEPTH):0]  count
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [2:0]    c_op_reserved = 3'b111;
    localparam logic [AW-1:0] c_ptr_one     = 1;
    localparam logic [AW:0]   c_cnt_one     = 1;
    localparam logic [AW:0]   c_cnt_full    = (AW+1)'(DEPTH);

    // FIFO storage: data only, no reset needed since occupancy gates its use
    logic [2:0]       r_op_mem  [DEPTH];
    logic [31:0]      r_x_mem   [DEPTH];
    logic [31:0]      r_y_mem   [DEPTH];
    logic [TAG_W-1:0] r_tag_mem [DEPTH];

    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic             r_res_valid;
    logic [31:0]      r_res_z;
    logic [2:0]       r_res_flags;
    logic [TAG_W-1:0] r_res_tag;
    logic             r_res_illegal;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_fire;

    assign w_full  = (r_count == c_cnt_full);
    assign w_empty = (r_count == '0);

    // Push is gated by !full only; a pop on the same edge does not open a slot
    // for the current cycle, so there is no ready-to-ready combinational path.
    assign w_push  = cmd_valid && !w_full && !flush;
    // Issue whenever the head exists and the result slot is free or draining.
    assign w_fire  = !w_empty && (!r_res_valid || res_ready);

    assign cmd_ready   = !w_full;
    assign count       = r_count;
    assign res_valid   = r_res_valid;
    assign res_z       = r_res_z;
    assign res_flags   = r_res_flags;
    assign res_tag     = r_res_tag;
    assign res_illegal = r_res_illegal;

    // Head entry drives the ALU; idle value is the reserved op with zero operands
    always_comb begin
        alu_x  = '0;
        alu_y  = '0;
        alu_op = c_op_reserved;
        if (!w_empty) begin
            alu_x  = r_x_mem[r_rd_ptr];
            alu_y  = r_y_mem[r_rd_ptr];
            alu_op = r_op_mem[r_rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_op_mem[r_wr_ptr]  <= cmd_op;
            r_x_mem[r_wr_ptr]   <= cmd_x;
            r_y_mem[r_wr_ptr]   <= cmd_y;
            r_tag_mem[r_wr_ptr] <= cmd_tag;
        end
    end

    // Pointers, occupancy and result-valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_res_valid <= 1'b0;
        end else if (flush) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_res_valid <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_fire) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push, w_fire})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
            if (w_fire) begin
                r_res_valid <= 1'b1;
            end else if (res_ready) begin
                r_res_valid <= 1'b0;
            end
        end
    end

    // Result data: captured on issue, held otherwise (including across drain)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_z       <= '0;
            r_res_flags   <= '0;
            r_res_tag     <= '0;
            r_res_illegal <= 1'b0;
        end else if (w_fire && !flush) begin
            r_res_z       <= alu_z;
            r_res_flags   <= {alu_overflow, alu_equal, alu_zero};
            r_res_tag     <= r_tag_mem[r_rd_ptr];
            r_res_illegal <= (r_op_mem[r_rd_ptr] == c_op_reserved);
        end
    end

`ifdef ALU_STICKY_OVF_EN
    logic r_sticky_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky_ovf <= 1'b0;
        end else if (flush) begin
            r_sticky_ovf <= 1'b0;
        end else if (w_fire && alu_overflow) begin
            r_sticky_ovf <= 1'b1;
        end
    end

    assign sticky_ovf = r_sticky_ovf;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_cmd_queue.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_alu_cmd_queue
// Purpose  : Directed self-checking bench for alu_cmd_queue, with a small
//            behavioural ALU closing the loop between alu_* outputs and inputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_cmd_queue;

    localparam int DEPTH = 4;
    localparam int TAG_W = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    localparam logic [2:0] c_op_add = 3'd0;
    localparam logic [2:0] c_op_sub = 3'd1;
    localparam logic [2:0] c_op_and = 3'd2;
    localparam logic [2:0] c_op_or  = 3'd3;
    localparam logic [2:0] c_op_xor = 3'd4;
    localparam logic [2:0] c_op_slt = 3'd5;
    localparam logic [2:0] c_op_rsv = 3'd7;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [31:0]      cmd_x;
    logic [31:0]      cmd_y;
    logic [TAG_W-1:0] cmd_tag;
    logic [31:0]      alu_x;
    logic [31:0]      alu_y;
    logic [2:0]       alu_op;
    logic [31:0]      alu_z;
    logic             alu_zero;
    logic             alu_equal;
    logic             alu_overflow;
    logic             res_valid;
    logic             res_ready;
    logic [31:0]      res_z;
    logic [2:0]       res_flags;
    logic [TAG_W-1:0] res_tag;
    logic             res_illegal;
    logic [CW-1:0]    count;
`ifdef ALU_STICKY_OVF_EN
    logic             sticky_ovf;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alu_cmd_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_x        (cmd_x),
        .cmd_y        (cmd_y),
        .cmd_tag      (cmd_tag),
        .alu_x        (alu_x),
        .alu_y        (alu_y),
        .alu_op       (alu_op),
        .alu_z        (alu_z),
        .alu_zero     (alu_zero),
        .alu_equal    (alu_equal),
        .alu_overflow (alu_overflow),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_z        (res_z),
        .res_flags    (res_flags),
        .res_tag      (res_tag),
        .res_illegal  (res_illegal),
`ifdef ALU_STICKY_OVF_EN
        .sticky_ovf   (sticky_ovf),
`endif
        .count        (count)
    );

    // Behavioural ALU; the reserved op yields zero and suppresses equal
    always_comb begin
        alu_z        = '0;
        alu_overflow = 1'b0;
        alu_equal    = (alu_x == alu_y);
        case (alu_op)
            c_op_add: begin
                alu_z        = alu_x + alu_y;
                alu_overflow = (alu_x[31] == alu_y[31]) && (alu_z[31] != alu_x[31]);
            end
            c_op_sub: begin
                alu_z        = alu_x - alu_y;
                alu_overflow = (alu_x[31] != alu_y[31]) && (alu_z[31] != alu_x[31]);
            end
            c_op_and: alu_z = alu_x & alu_y;
            c_op_or:  alu_z = alu_x | alu_y;
            c_op_xor: alu_z = alu_x ^ alu_y;
            c_op_slt: alu_z = ($signed(alu_x) < $signed(alu_y)) ? 32'd1 : 32'd0;
            default:  alu_equal = 1'b0;
        endcase
        alu_zero = (alu_z == '0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] x,
                         input logic [31:0] y, input logic [TAG_W-1:0] tag);
        cmd_valid = v;
        cmd_op    = op;
        cmd_x     = x;
        cmd_y     = y;
        cmd_tag   = tag;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_checks++; if (count !== 3'd0) begin n_errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        n_checks++; if (cmd_ready !== 1'b1) begin n_errors++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
        n_checks++; if (res_valid !== 1'b0) begin n_errors++; $display("FAIL reset_res_valid: got %b expected 0", res_valid); end
        n_checks++; if (res_z !== 32'd0) begin n_errors++; $display("FAIL reset_res_z: got %h expected 0", res_z); end
        n_checks++; if (res_flags !== 3'b000) begin n_errors++; $display("FAIL reset_res_flags: got %b expected 000", res_flags); end
        n_checks++; if (res_tag !== 4'd0) begin n_errors++; $display("FAIL reset_res_tag: got %0d expected 0", res_tag); end
        n_checks++; if (res_illegal !== 1'b0) begin n_errors++; $display("FAIL reset_res_illegal: got %b expected 0", res_illegal); end
        n_checks++; if (alu_op !== 3'b111) begin n_errors++; $display("FAIL reset_alu_op: got %b expected 111", alu_op); end
        n_checks++; if (alu_x !== 32'd0 || alu_y !== 32'd0) begin n_errors++; $display("FAIL reset_alu_xy: got %h/%h expected 0/0", alu_x, alu_y); end
`ifdef ALU_STICKY_OVF_EN
        n_checks++; if (sticky_ovf !== 1'b0) begin n_errors++; $display("FAIL reset_sticky: got %b expected 0", sticky_ovf); end
`endif
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_add();
        res_ready = 1'b1;
        drive(1'b1, c_op_add, 32'h7FFF_FFFF, 32'd1, 4'd3);
        tick();
        drive(1'b0, c_op_add, 32'd0, 32'd0, 4'd0);
        n_checks++; if (count !== 3'd1) begin n_errors++; $display("FAIL add_count_e: got %0d expected 1", count); end
        n_checks++; if (res_valid !== 1'b0) begin n_errors++; $display("FAIL add_valid_e: got %b expected 0", res_valid); end
        n_checks++; if (alu_x !== 32'h7FFF_FFFF || alu_op !== c_op_add) begin n_errors++; $display("FAIL add_head: got x=%h op=%0d expected x=7fffffff op=0", alu_x, alu_op); end
        tick();
        n_checks++; if (res_valid !== 1'b1) begin n_errors++; $display("FAIL add_valid: got %b expected 1", res_valid); end
        n_checks++; if (res_z !== 32'h8000_0000) begin n_errors++; $display("FAIL add_z: got %h expected 80000000", res_z); end
        n_checks++; if (res_flags !== 3'b100) begin n_errors++; $display("FAIL add_flags: got %b expected 100", res_flags); end
        n_checks++; if (res_tag !== 4'd3) begin n_errors++; $display("FAIL add_tag: got %0d expected 3", res_tag); end
        n_checks++; if (res_illegal !== 1'b0) begin n_errors++; $display("FAIL add_illegal: got %b expected 0", res_illegal); end
        n_checks++; if (count !== 3'd0) begin n_errors++; $display("FAIL add_count: got %0d expected 0", count); end
        tick();
        n_checks++; if (res_valid !== 1'b0) begin n_errors++; $display("FAIL add_drain: got %b expected 0", res_valid); end
        n_checks++; if (res_z !== 32'h8000_0000) begin n_errors++; $display("FAIL add_hold_z: got %h expected 80000000", res_z); end
    endtask

    task automatic test_backpressure();
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, c_op_sub, 32'h100 + 32'(3 * i), 32'(i), TAG_W'(i));
            tick();
        end
        n_checks++; if (res_valid !== 1'b1) begin n_errors++; $display("FAIL bp_valid: got %b expected 1", res_valid); end
        n_checks++; if (count !== 3'd4) begin n_errors++; $display("FAIL bp_count: got %0d expected 4", count); end
        n_checks++; if (cmd_ready !== 1'b0) begin n_errors++; $display("FAIL bp_ready: got %b expected 0", cmd_ready); end
        // sixth push is held off while full; result slot stays frozen
        drive(1'b1, c_op_sub, 32'h999, 32'd1, 4'd5);
        tick();
        n_checks++; if (count !== 3'd4) begin n_errors++; $display("FAIL bp_full_count: got %0d expected 4", count); end
        n_checks++; if (res_tag !== 4'd0 || res_z !== 32'h100) begin n_errors++; $display("FAIL bp_stable: got tag=%0d z=%h expected tag=0 z=100", res_tag, res_z); end
        drive(1'b0, c_op_add, 32'd0, 32'd0, 4'd0);
        res_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (res_valid !== 1'b1 || res_tag !== TAG_W'(i) || res_z !== 32'h100 + 32'(2 * i) || count !== CW'(4 - i)) begin
                n_errors++;
                $display("FAIL bp_drain_%0d: got v=%b tag=%0d z=%h cnt=%0d expected v=1 tag=%0d z=%h cnt=%0d",
                         i, res_valid, res_tag, res_z, count, i, 32'h100 + 32'(2 * i), 4 - i);
            end
            tick();
        end
        n_checks++; if (res_valid !== 1'b0 || count !== 3'd0) begin n_errors++; $display("FAIL bp_empty: got v=%b cnt=%0d expected v=0 cnt=0", res_valid, count); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_z;
        res_ready = 1'b1;
        for (int c = 0; c <= 8; c++) begin
            if (c < 8) drive(1'b1, c_op_slt, 32'(c), 32'd4, TAG_W'(c));
            else       drive(1'b0, c_op_add, 32'd0, 32'd0, 4'd0);
            tick();
            if (c >= 1) begin
                exp_z = (c - 1 < 4) ? 32'd1 : 32'd0;
                n_checks++;
                if (res_valid !== 1'b1 || res_z !== exp_z || res_tag !== TAG_W'(c - 1)) begin
                    n_errors++;
                    $display("FAIL stream_%0d: got v=%b z=%h tag=%0d expected v=1 z=%h tag=%0d",
                             c - 1, res_valid, res_z, res_tag, exp_z, c - 1);
                end
            end
        end
        tick();
        n_checks++; if (res_valid !== 1'b0) begin n_errors++; $display("FAIL stream_end: got %b expected 0", res_valid); end
    endtask

    task automatic test_reserved();
        res_ready = 1'b1;
        drive(1'b1, c_op_rsv, 32'd5, 32'd5, 4'd9);
        tick();
        drive(1'b0, c_op_add, 32'd0, 32'd0, 4'd0);
        tick();
        n_checks++; if (res_valid !== 1'b1 || res_illegal !== 1'b1) begin n_errors++; $display("FAIL rsv_illegal: got v=%b ill=%b expected 1/1", res_valid, res_illegal); end
        n_checks++; if (res_flags[1] !== 1'b0) begin n_errors++; $display("FAIL rsv_equal: got %b expected 0", res_flags[1]); end
        n_checks++; if (res_tag !== 4'd9) begin n_errors++; $display("FAIL rsv_tag: got %0d expected 9", res_tag); end
        tick();
    endtask

    task automatic test_flush_reset();
        res_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, c_op_add, 32'(i), 32'd1, TAG_W'(i));
            tick();
        end
        n_checks++; if (count !== 3'd3 || res_valid !== 1'b1) begin n_errors++; $display("FAIL flush_pre: got cnt=%0d v=%b expected 3/1", count, res_valid); end
        // flush beats a simultaneous push and issue
        flush = 1'b1;
        res_ready = 1'b1;
        drive(1'b1, c_op_add, 32'd7, 32'd7, 4'd15);
        tick();
        flush = 1'b0;
        drive(1'b0, c_op_add, 32'd0, 32'd0, 4'd0);
        n_checks++; if (count !== 3'd0 || res_valid !== 1'b0 || cmd_ready !== 1'b1) begin n_errors++; $display("FAIL flush_clear: got cnt=%0d v=%b rdy=%b expected 0/0/1", count, res_valid, cmd_ready); end
        n_checks++; if (alu_op !== 3'b111) begin n_errors++; $display("FAIL flush_alu_op: got %b expected 111", alu_op); end
        tick();
        n_checks++; if (count !== 3'd0 || res_valid !== 1'b0) begin n_errors++; $display("FAIL flush_after: got cnt=%0d v=%b expected 0/0", count, res_valid); end

        res_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, c_op_add, 32'(i), 32'd1, TAG_W'(i + 1));
            tick();
        end
        n_checks++; if (count !== 3'd3 || res_valid !== 1'b1) begin n_errors++; $display("FAIL rst_pre: got cnt=%0d v=%b expected 3/1", count, res_valid); end
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++; if (count !== 3'd0 || res_valid !== 1'b0 || cmd_ready !== 1'b1) begin n_errors++; $display("FAIL rst_async: got cnt=%0d v=%b rdy=%b expected 0/0/1", count, res_valid, cmd_ready); end
        n_checks++; if (res_z !== 32'd0 || res_tag !== 4'd0 || alu_op !== 3'b111) begin n_errors++; $display("FAIL rst_data: got z=%h tag=%0d op=%b expected 0/0/111", res_z, res_tag, alu_op); end
        drive(1'b0, c_op_add, 32'd0, 32'd0, 4'd0);
        #2;
        rst_n = 1'b1;
        res_ready = 1'b1;
        tick();
    endtask

`ifdef ALU_STICKY_OVF_EN
    task automatic test_sticky();
        res_ready = 1'b1;
        n_checks++; if (sticky_ovf !== 1'b0) begin n_errors++; $display("FAIL sticky_init: got %b expected 0", sticky_ovf); end
        drive(1'b1, c_op_add, 32'h7FFF_FFFF, 32'd1, 4'd1);
        tick();
        drive(1'b1, c_op_and, 32'd0, 32'd0, 4'd2);
        tick();
        drive(1'b0, c_op_add, 32'd0, 32'd0, 4'd0);
        n_checks++; if (sticky_ovf !== 1'b1) begin n_errors++; $display("FAIL sticky_set: got %b expected 1", sticky_ovf); end
        tick();
        n_checks++; if (sticky_ovf !== 1'b1 || res_tag !== 4'd2 || res_flags !== 3'b011) begin n_errors++; $display("FAIL sticky_hold: got s=%b tag=%0d fl=%b expected 1/2/011", sticky_ovf, res_tag, res_flags); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_checks++; if (sticky_ovf !== 1'b0) begin n_errors++; $display("FAIL sticky_flush: got %b expected 0", sticky_ovf); end
    endtask
`endif

    initial begin
        flush     = 1'b0;
        res_ready = 1'b0;
        drive(1'b0, c_op_add, 32'd0, 32'd0, 4'd0);
        test_reset();
        test_single_add();
        test_backpressure();
        test_back_to_back();
        test_reserved();
        test_flush_reset();
`ifdef ALU_STICKY_OVF_EN
        test_sticky();
`endif
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
